// File: rtl/button_pkg.sv
// Shared definitions for the multi-button debouncer: per-channel FSM encoding
// and default timing constants (cycle counts assume a 50 MHz clock).
package button_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_LONG = 2'd2
  } btn_state_e;

  localparam int DEF_N_BTN             = 4;
  localparam int DEF_DEBOUNCE_CYCLES   = 500000;
  localparam int DEF_LONG_PRESS_CYCLES = 50000000;
  localparam int DEF_REPEAT_CYCLES     = 10000000;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchronizer, stability-counter debouncer and
// IDLE/HELD/LONG press FSM. Auto-repeat is built only with BUTTON_AUTO_REPEAT_EN.
module debounce_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES
`ifdef BUTTON_AUTO_REPEAT_EN
  , parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic debounce,
  output logic press,
  output logic release_pulse,
  output logic long_press
);

  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_PRESS_CYCLES - 1);

  logic [1:0]        sync_q, sync_d;
  logic              deb_q, deb_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  btn_state_e        state_q, state_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              long_q, long_d;
  logic              rise, fall;

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYCLES);
  localparam logic [REP_W-1:0] REP_MAX = REP_W'(REPEAT_CYCLES - 1);
  logic [REP_W-1:0] rep_q, rep_d;
`endif

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    sync_d = {sync_q[0], btn_raw};
    deb_d  = deb_q;
    cnt_d  = '0;
    if (sync_q[1] != deb_q) begin
      if (cnt_q == CNT_MAX) begin
        deb_d = ~deb_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    rise = deb_d & ~deb_q;
    fall = ~deb_d & deb_q;
  end

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    press_d   = rise;
    release_d = fall;
    long_d    = 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
    rep_d     = rep_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d = ST_HELD;
          hold_d  = '0;
        end
      end
      ST_HELD: begin
        if (fall) begin
          state_d = ST_IDLE;
        end else if (hold_q == HOLD_MAX) begin
          state_d = ST_LONG;
          long_d  = 1'b1;
`ifdef BUTTON_AUTO_REPEAT_EN
          rep_d   = '0;
`endif
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      ST_LONG: begin
        if (fall) begin
          state_d = ST_IDLE;
        end
`ifdef BUTTON_AUTO_REPEAT_EN
        // Repeat phase counts from the long_press pulse, one press per period.
        else if (rep_q == REP_MAX) begin
          press_d = 1'b1;
          rep_d   = '0;
        end else begin
          rep_d = rep_q + REP_W'(1);
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q    <= '0;
      deb_q     <= 1'b0;
      cnt_q     <= '0;
      hold_q    <= '0;
      state_q   <= ST_IDLE;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
      rep_q     <= '0;
`endif
    end else begin
      sync_q    <= sync_d;
      deb_q     <= deb_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      state_q   <= state_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
`ifdef BUTTON_AUTO_REPEAT_EN
      rep_q     <= rep_d;
`endif
    end
  end

  assign debounce      = deb_q;
  assign press         = press_q;
  assign release_pulse = release_q;
  assign long_press    = long_q;

endmodule

// File: rtl/multi_button_debounce.sv
// N_BTN independent debounced buttons with press/release/long-press pulses.
// Define BUTTON_AUTO_REPEAT_EN for auto-repeat press pulses while in long hold.
// The release output is release_pulse because "release" is a reserved word.
module multi_button_debounce
  import button_pkg::*;
#(
  parameter int N_BTN             = DEF_N_BTN,
  parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
  parameter int REPEAT_CYCLES     = DEF_REPEAT_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn,
  output logic [N_BTN-1:0] debounce,
  output logic [N_BTN-1:0] press,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] long_press
);

  if (N_BTN < 1 || N_BTN > 16) begin : g_bad_n_btn
    $error("N_BTN must be in 1..16");
  end
  if (DEBOUNCE_CYCLES < 2 || LONG_PRESS_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_timing
    $error("need DEBOUNCE_CYCLES >= 2 and LONG_PRESS_CYCLES > DEBOUNCE_CYCLES");
  end
  if (REPEAT_CYCLES < 2) begin : g_bad_repeat
    $error("REPEAT_CYCLES must be >= 2");
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
`ifdef BUTTON_AUTO_REPEAT_EN
      , .REPEAT_CYCLES  (REPEAT_CYCLES)
`endif
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .btn_raw      (btn[i]),
      .debounce     (debounce[i]),
      .press        (press[i]),
      .release_pulse(release_pulse[i]),
      .long_press   (long_press[i])
    );
  end

endmodule

// File: doc/multi_button_debounce.md
MULTI_BUTTON_DEBOUNCE -- requirements
Module: multi_button_debounce

Interface
REQ-001 SHALL have parameter N_BTN, default 4, number of independent button channels (1..16).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 500000, consecutive stable cycles required to change debounced state (>=2).
REQ-003 SHALL have parameter LONG_PRESS_CYCLES, default 50000000, held cycles after debounced rise before long-press event (>DEBOUNCE_CYCLES).
REQ-004 SHALL have parameter REPEAT_CYCLES, default 10000000, auto-repeat period (>=2); used only when the REQ-025 macro is defined.
REQ-005 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-007 SHALL have port btn  input  N_BTN  raw asynchronous button levels, active-high.
REQ-008 SHALL have port debounce  output  N_BTN  debounced level per channel.
REQ-009 SHALL have port press  output  N_BTN  one-cycle pulse on debounced rise (plus auto-repeat pulses).
REQ-010 SHALL have port release  output  N_BTN  one-cycle pulse on debounced fall.
REQ-011 SHALL have port long_press  output  N_BTN  one-cycle pulse when hold reaches LONG_PRESS_CYCLES.

Function
REQ-012 Each btn bit SHALL pass through a 2-flop synchronizer before any other logic; channels fully independent.
REQ-013 Per channel, a stability counter SHALL increment each cycle the synchronized input differs from debounce, and clear to 0 on any cycle it equals debounce.
REQ-014 When the counter reaches DEBOUNCE_CYCLES-1 while still differing, debounce SHALL toggle on the next edge and the counter SHALL clear.
REQ-015 Latency: btn stable from edge t SHALL give debounce change at edge t+2+DEBOUNCE_CYCLES exactly; any glitch shorter than DEBOUNCE_CYCLES SHALL produce no output change.
REQ-016 press SHALL be high exactly in the cycle debounce first reads 1; release exactly in the cycle debounce first reads 0; never both in one cycle per channel.
REQ-017 Per-channel FSM states: IDLE (debounce=0), HELD (debounce=1, long not yet reached), LONG (debounce=1, long reached); IDLE->HELD on debounced rise; HELD->LONG on hold counter = LONG_PRESS_CYCLES-1; HELD/LONG->IDLE on debounced fall.
REQ-018 Hold counter SHALL clear on entering HELD, increment each HELD cycle, and not advance in IDLE.
REQ-019 long_press SHALL pulse once, in the cycle of the HELD->LONG transition; a release before that SHALL produce no long_press.
REQ-020 Counter widths SHALL be $clog2 of the respective max count; counters SHALL saturate, never wrap.
REQ-021 Simultaneous events on different channels SHALL all be reported in the same cycle.

Reset
REQ-022 While reset=0 at a clk edge: synchronizers, counters to 0, FSM to IDLE, debounce/press/release/long_press to 0.
REQ-023 Reset mid-press SHALL drop debounce to 0 with no release pulse; a button still held after reset SHALL re-debounce from scratch and produce press.
REQ-024 First press after reset SHALL need the full DEBOUNCE_CYCLES.

Configuration
REQ-025 Macro BUTTON_AUTO_REPEAT_EN defined: in LONG, press SHALL additionally pulse every REPEAT_CYCLES cycles, first pulse REPEAT_CYCLES cycles after the long_press pulse, until release.
REQ-026 Macro undefined: no repeat logic synthesized; press pulses only on debounced rise; REPEAT_CYCLES ignored.

Structure
REQ-027 Shared package button_pkg SHALL hold FSM state encoding (IDLE, HELD, LONG) and default timing constants.
REQ-028 Per-channel logic SHALL be sub-module debounce_channel, instantiated N_BTN times by generate loop; top holds only parameters and wiring.

Verification (N_BTN=4, DEBOUNCE_CYCLES=8, LONG_PRESS_CYCLES=32, REPEAT_CYCLES=16)
REQ-029 btn[0] toggled every cycle for 5 cycles then 0 -> all outputs stay 0.
REQ-030 btn[1]=1 at edge t, held 20 cycles -> debounce[1] rises at t+10, press[1] one pulse at t+10, release[1] pulse 8+2 cycles after btn drops, no long_press.
REQ-031 btn[2] held 60 cycles -> long_press[2] single pulse 32 cycles after press[2]; with BUTTON_AUTO_REPEAT_EN, press[2] repeats at +16 after long_press until release; without it, none.
REQ-032 btn[0] and btn[3] raised at same edge -> press[0] and press[3] in same cycle; other channels quiet.
REQ-033 reset=0 for 1 cycle while btn[1] held in LONG -> debounce[1]=0 with no release, then press[1] 10 cycles after reset deasserts.
